// File: rtl/button_debounce_if.sv
// Button-side signal bundle for button_debounce.
// The pulse signals exist only when DEBOUNCE_EDGE_PULSE_EN is defined.
`timescale 1ns/1ps
interface button_debounce_if;
  logic button_in;
  logic button_out;
`ifdef DEBOUNCE_EDGE_PULSE_EN
  logic press_pulse;
  logic release_pulse;

  modport master (output button_in, input button_out, input press_pulse, input release_pulse);
  modport slave  (input button_in, output button_out, output press_pulse, output release_pulse);
`else
  modport master (output button_in, input button_out);
  modport slave  (input button_in, output button_out);
`endif
endinterface

// File: rtl/button_debounce.sv
// Synchronizes and debounces a mechanical push-button into a clean registered level.
// Optional DEBOUNCE_EDGE_PULSE_EN adds one-cycle press/release pulses.
`timescale 1ns/1ps
module button_debounce #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  button_debounce_if.slave   btn
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_chain_q;
  logic                   sync_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   out_q, out_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_chain_q <= '0;
    end else begin
      sync_chain_q <= {sync_chain_q[SYNC_STAGES-2:0], btn.button_in};
    end
  end

  assign sync_q = sync_chain_q[SYNC_STAGES-1];

  // Any cycle where the synced level matches the output restarts qualification.
  always_comb begin
    cnt_d = '0;
    out_d = out_q;
    if (sync_q != out_q) begin
      if (cnt_q == CntLast) begin
        out_d = sync_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      out_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign btn.button_out = out_q;

`ifdef DEBOUNCE_EDGE_PULSE_EN
  logic press_q;
  logic release_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      press_q   <= out_d & ~out_q;
      release_q <= ~out_d & out_q;
    end
  end

  assign btn.press_pulse   = press_q;
  assign btn.release_pulse = release_q;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Randomized self-checking bench for button_debounce with a run-length reference model.
`timescale 1ns/1ps
module tb_button_debounce;

  localparam int SYNC   = 2;
  localparam int STABLE = 4;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  button_debounce_if dut_if ();

  button_debounce #(
    .SYNC_STAGES   (SYNC),
    .STABLE_CYCLES (STABLE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (dut_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the level seen by the counter at edge k is the input sampled SYNC edges
  // earlier; the output flips once the last STABLE such levels all differ from it.
  bit m_in_q[$];
  bit m_sync_q[$];
  bit exp_out   = 1'b0;
  bit exp_press = 1'b0;
  bit exp_rel   = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_in_q.delete();
      m_sync_q.delete();
      exp_out   = 1'b0;
      exp_press = 1'b0;
      exp_rel   = 1'b0;
    end else begin : model_step
      bit s;
      bit flip;
      m_in_q.push_back(dut_if.button_in);
      s = 1'b0;
      if (m_in_q.size() > SYNC) s = m_in_q.pop_front();
      m_sync_q.push_back(s);
      if (m_sync_q.size() > STABLE) void'(m_sync_q.pop_front());
      flip = (m_sync_q.size() == STABLE);
      foreach (m_sync_q[i]) if (m_sync_q[i] == exp_out) flip = 1'b0;
      exp_press = flip && !exp_out;
      exp_rel   = flip && exp_out;
      if (flip) exp_out = !exp_out;
    end
  end

  always @(negedge clk) begin
    check("out_vs_model", int'(dut_if.button_out), int'(exp_out));
`ifdef DEBOUNCE_EDGE_PULSE_EN
    check("press_vs_model", int'(dut_if.press_pulse), int'(exp_press));
    check("release_vs_model", int'(dut_if.release_pulse), int'(exp_rel));
    check("pulse_exclusive", int'(dut_if.press_pulse & dut_if.release_pulse), 0);
`endif
  end

  // Samples the output every ns (offset from edges) and reports its transitions.
  task automatic watch(input int ns, output int changes, output realtime t_first);
    bit last;
    last    = dut_if.button_out;
    changes = 0;
    t_first = 0.0;
    #0.5;
    for (int i = 0; i < ns; i++) begin
      if (dut_if.button_out != last) begin
        if (changes == 0) t_first = $realtime;
        changes++;
        last = dut_if.button_out;
      end
      #1;
    end
  endtask

  // Five toggles at 3 ns spacing ending on level fin; returns the time of the last toggle.
  task automatic bounce(input bit fin, output realtime t_last);
    @(posedge clk);
    #2;
    for (int i = 0; i < 5; i++) begin
      dut_if.button_in = (i % 2 == 0) ? fin : !fin;
      t_last = $realtime;
      if (i < 4) #3;
    end
  endtask

  initial begin : main
    int      rise;
    int      changes;
    realtime t_last;
    realtime t_first;
    int      press_lat;
    int      rel_lat;

    rst_n = 1'b1;
    dut_if.button_in = 1'b1;
    #1 rst_n = 1'b0;

    // Button held during reset: output stays low.
    repeat (3) begin
      @(negedge clk);
      check("reset_hold_out", int'(dut_if.button_out), 0);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    rise = 0;
    for (int e = 1; e <= 20 && rise == 0; e++) begin
      @(posedge clk);
      #1;
      if (dut_if.button_out) rise = e;
    end
    check("reset_release_latency", rise, 6);

    // Back to a stable 0.
    @(posedge clk);
    #3 dut_if.button_in = 1'b0;
    repeat (12) @(posedge clk);
    #1 check("settled_low", int'(dut_if.button_out), 0);

    // Bouncy press then bouncy release.
    bounce(1'b1, t_last);
    watch(100, changes, t_first);
    press_lat = int'(t_first - t_last);
    check("press_one_edge", changes, 1);
    check("press_final_high", int'(dut_if.button_out), 1);
    check("press_within_70ns", int'(press_lat <= 70), 1);

    bounce(1'b0, t_last);
    watch(100, changes, t_first);
    rel_lat = int'(t_first - t_last);
    check("release_one_edge", changes, 1);
    check("release_final_low", int'(dut_if.button_out), 0);
    check("release_latency_match", rel_lat, press_lat);

    // Glitch of three cycles is rejected.
    @(posedge clk);
    #2 dut_if.button_in = 1'b1;
    repeat (3) @(posedge clk);
    #2 dut_if.button_in = 1'b0;
    watch(80, changes, t_first);
    check("glitch_rejected", changes, 0);

    // Async reset while qualifying a release (counter at 2).
    @(posedge clk);
    #2 dut_if.button_in = 1'b1;
    repeat (12) @(posedge clk);
    #1 check("pre_reset_high", int'(dut_if.button_out), 1);
    @(posedge clk);
    #2 dut_if.button_in = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check("async_reset_clears", int'(dut_if.button_out), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    watch(60, changes, t_first);
    check("post_reset_quiet", changes, 0);

    // Randomized phase: random hold lengths, sub-cycle bounces and occasional resets.
    for (int seg = 0; seg < 400; seg++) begin
      @(posedge clk);
      #($urandom_range(1, 9));
      if ($urandom_range(0, 39) == 0) begin
        rst_n = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #($urandom_range(1, 9));
        rst_n = 1'b1;
      end else if ($urandom_range(0, 3) == 0) begin
        bit fin;
        fin = 1'($urandom_range(0, 1));
        bounce(fin, t_last);
        repeat ($urandom_range(1, 12)) @(posedge clk);
      end else begin
        dut_if.button_in = 1'($urandom_range(0, 1));
        repeat ($urandom_range(1, 12)) @(posedge clk);
      end
    end

    repeat (10) @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
